keypad_scan_fsm: RTL and testbench
==================================

// Module: keypad_scan_fsm
// PURPOSE
//   Control stage paired with the 2-bit column scan counter. It pulses
//   scan_counter_en to step the counter and decodes the counter's
//   encoded_cols into active-low column drives for the 4x4 keypad.
//   It also synchronizes the row inputs and debounces press and release.
//   Each debounced press gives exactly one key_valid pulse with a 4-bit key position.
// PARAMETERS
//   SCAN_DIV         4800    clk cycles per column dwell; must be >= 4
//   DEBOUNCE_CYCLES  960000  consecutive stable cycles for press/release; >= 2
// PORTS
//   clk              in   1  system clock
//   reset            in   1  synchronous, active-high reset
//   encoded_cols     in   2  current column index from scan counter
//   rows_n           in   4  raw keypad rows, active low (pulled up), async
//   scan_counter_en  out  1  one-cycle pulse: advance scan counter
//   cols_n           out  4  column drive, active low: ~(4'b0001 << encoded_cols)
//   key_code         out  4  {row_idx[1:0], col_idx[1:0]} of last valid key
//   key_valid        out  1  one-cycle pulse per debounced press
//   key_held         out  1  high while debounced key is held (HELD/RELEASE)
// BEHAVIOUR
//   - Reset (sync, priority over all): state=SCAN, dwell=0, deb=0;
//     scan_counter_en=0, key_code=0, key_valid=0, key_held=0, row_idx/col_idx=0.
//   - cols_n is combinational from encoded_cols; it is valid during reset too.
//   - rows_n passes through a 2-FF synchronizer (rs), 2 cycles latency;
//     the sync flops reset to 4'hF.
//   - dwell: counter 0..SCAN_DIV-1, runs only in SCAN, clears on leaving SCAN.
//   - SCAN: at dwell==SCAN_DIV-1 sample rs.
//       rs==4'hF -> scan_counter_en=1 for that cycle, dwell wraps to 0.
//       any row low -> latch row_idx=lowest low row index, col_idx=encoded_cols,
//         deb=0, go DEBOUNCE; no enable pulse (column frozen).
//       Otherwise scan_counter_en=0.
//   - DEBOUNCE: scan_counter_en=0. Each cycle with rs[row_idx]==0: deb++.
//       rs[row_idx]==1 -> go SCAN, dwell=0, no key_valid.
//       deb==DEBOUNCE_CYCLES-1 and row low -> key_code={row_idx,col_idx},
//         key_valid=1 for one cycle, go HELD.
//   - HELD: key_held=1. rs[row_idx]==1 -> deb=0, go RELEASE.
//   - RELEASE: key_held=1. rs[row_idx]==0 -> go HELD, with no new pulse.
//       deb reaching DEBOUNCE_CYCLES-1 with row high -> go SCAN, dwell=0.
//   - Other rows and other columns are ignored outside SCAN, so one key is
//     handled at a time and there is no rollover.
//   - key_code holds its value until the next valid press.
//   - key_valid and scan_counter_en are never high in the same cycle.
//   - The counter wraps 3->0 by itself; this block never loads it.
//   - All counters are sized with $clog2 of their parameter; no overflow
//     past the terminal value.
// TESTING  (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
//   1 Idle, rows_n=4'hF for 40 cycles after reset -> scan_counter_en pulses
//     on every 4th cycle (dwell==3); key_valid stays 0; cols_n tracks the model.
//   2 Row 2 low on column 1, held for 60 cycles -> exactly one key_valid pulse
//     with key_code=4'b1001. scan_counter_en=0 from detection until the
//     release debounce completes; key_held=1 from the pulse until the return to SCAN.
//   3 Press bounce: row low for 3 cycles after detection, then high -> no
//     key_valid; return to SCAN and scan_counter_en pulses again after 4 cycles.
//   4 Release bounce: in HELD, row high 3 cycles, low 2, high 20 -> no second
//     key_valid; key_held stays 1 through the bounce and drops 8 cycles after
//     the final release.
//   5 Rows 1 and 3 low on column 2 -> key_code=4'b0110 (lowest row wins).
//   6 Reset pulsed for 1 cycle in HELD with the key still down -> all outputs
//     are 0 the next cycle and state is SCAN. Re-detection follows, then one
//     new key_valid with the same key_code.

Source files
------------

// File: rtl/keypad_scan_fsm_if.sv
// Keypad scanner bus: column counter handshake, keypad lines and
// the debounced key report.
interface keypad_scan_fsm_if;
    logic [1:0] encoded_cols;
    logic [3:0] rows_n;
    logic       scan_counter_en;
    logic [3:0] cols_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  encoded_cols,
        input  rows_n,
        output scan_counter_en,
        output cols_n,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output encoded_cols,
        output rows_n,
        input  scan_counter_en,
        input  cols_n,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_fsm.sv
// 4x4 keypad scan control: steps the column counter, synchronizes
// rows, debounces press/release and reports one pulse per key press.
module keypad_scan_fsm #(
    parameter int SCAN_DIV        = 4800,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input logic               clk,
    input logic               reset,
    keypad_scan_fsm_if.master bus
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_nxt;
    logic [BW-1:0] deb;
    logic [BW-1:0] deb_nxt;
    logic [1:0]    row_idx;
    logic [1:0]    row_idx_nxt;
    logic [1:0]    col_idx;
    logic [1:0]    col_idx_nxt;
    logic [3:0]    code_q;
    logic [3:0]    code_nxt;
    logic          en_q;
    logic          en_nxt;
    logic          valid_q;
    logic          valid_nxt;
    logic [3:0]    rs1;
    logic [3:0]    rs;
    logic [1:0]    low_row;
    logic          row_low;

    // Column drive follows the counter directly, reset or not.
    assign bus.cols_n = ~(4'b0001 << bus.encoded_cols);

    assign bus.scan_counter_en = en_q;
    assign bus.key_valid       = valid_q;
    assign bus.key_code        = code_q;
    assign bus.key_held        = (state == HELD) || (state == RELEASE);

    // Only the latched row matters once a key has been picked.
    assign row_low = ~rs[row_idx];

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1 <= 4'hF;
            rs  <= 4'hF;
        end else begin
            rs1 <= bus.rows_n;
            rs  <= rs1;
        end
    end

    // Lowest-numbered low row wins when several are pressed.
    always_comb begin
        low_row = 2'd3;
        priority case (1'b1)
            !rs[0]:  low_row = 2'd0;
            !rs[1]:  low_row = 2'd1;
            !rs[2]:  low_row = 2'd2;
            default: low_row = 2'd3;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SCAN;
            dwell   <= '0;
            deb     <= '0;
            row_idx <= 2'd0;
            col_idx <= 2'd0;
            code_q  <= 4'd0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            dwell   <= dwell_nxt;
            deb     <= deb_nxt;
            row_idx <= row_idx_nxt;
            col_idx <= col_idx_nxt;
            code_q  <= code_nxt;
            en_q    <= en_nxt;
            valid_q <= valid_nxt;
        end
    end

    // Scan, debounce and hold/release sequencing.
    always_comb begin
        state_nxt   = state;
        dwell_nxt   = dwell;
        deb_nxt     = deb;
        row_idx_nxt = row_idx;
        col_idx_nxt = col_idx;
        code_nxt    = code_q;
        en_nxt      = 1'b0;
        valid_nxt   = 1'b0;
        unique case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (rs == 4'hF) begin
                        en_nxt = 1'b1;
                    end else begin
                        row_idx_nxt = low_row;
                        col_idx_nxt = bus.encoded_cols;
                        deb_nxt     = '0;
                        state_nxt   = DEBOUNCE;
                    end
                end else begin
                    dwell_nxt = dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_low) begin
                    dwell_nxt = '0;
                    state_nxt = SCAN;
                end else if (deb == DEB_LAST) begin
                    code_nxt  = {row_idx, col_idx};
                    valid_nxt = 1'b1;
                    state_nxt = HELD;
                end else begin
                    deb_nxt = deb + 1'b1;
                end
            end
            HELD: begin
                if (!row_low) begin
                    deb_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (row_low) begin
                    state_nxt = HELD;
                end else if (deb == DEB_LAST) begin
                    dwell_nxt = '0;
                    state_nxt = SCAN;
                end else begin
                    deb_nxt = deb + 1'b1;
                end
            end
            default: begin
                state_nxt = SCAN;
            end
        endcase
    end

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Bench for keypad_scan_fsm: keypad matrix and column counter models,
// key-report scoreboard plus directed timing checks.
module tb_keypad_scan_fsm;

    localparam int SD = 4;
    localparam int DC = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    keypad_scan_fsm_if bus ();

    keypad_scan_fsm #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // pressed[row][col]: physical switch closed
    logic [3:0][3:0] pressed = '0;
    logic [1:0]      cnt;
    logic [3:0]      rows;
    logic [3:0]      exp_q [$];
    int              n_pass  = 0;
    int              n_total = 0;

    // 2-bit column scan counter stepped by the DUT
    always @(posedge clk) begin
        if (reset) cnt <= 2'd0;
        else if (bus.scan_counter_en) cnt <= cnt + 2'd1;
    end

    assign bus.encoded_cols = cnt;

    // Keypad matrix: a closed switch pulls its row low while its column is driven
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !bus.cols_n[c]) rows[r] = 1'b0;
    end

    assign bus.rows_n = rows;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: column decode every cycle, key reports against the scoreboard
    always @(negedge clk) begin : mon
        logic [3:0] cexp;
        cexp = ~(4'b0001 << cnt);
        chk("cols_n", bus.cols_n, cexp);
        if (!reset && bus.key_valid) begin
            chk("valid_en_exclusive", bus.scan_counter_en, 0);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL key_valid_unexpected: got code %h expected none",
                         bus.key_code);
            end else begin
                chk("key_code", bus.key_code, exp_q.pop_front());
            end
        end
    end

    // Returns on the negedge where the enable that selects column c is seen
    task automatic align_col(input logic [1:0] c);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.scan_counter_en && cnt == c - 2'd1) ok = 1'b1;
        end
        if (!ok) chk("align_timeout", 0, 1);
    endtask

    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (bus.key_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_en(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (bus.scan_counter_en) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int max, output int n,
                                 output int en_seen);
        n = -1;
        en_seen = 0;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk);
            if (!bus.key_held) begin
                n = k;
                break;
            end
            if (bus.scan_counter_en) en_seen++;
        end
    endtask

    initial begin : wdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int m;
        int e;
        int errs;
        int last;
        int npulse;
        logic [3:0] cexp;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_en", bus.scan_counter_en, 0);
        chk("rst_valid", bus.key_valid, 0);
        chk("rst_held", bus.key_held, 0);
        chk("rst_code", bus.key_code, 0);
        reset = 1'b0;

        // 1: idle scan, enable every 4th cycle
        npulse = 0;
        last = -1;
        errs = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.scan_counter_en) begin
                npulse++;
                if (last >= 0 && k - last != SD) errs++;
                last = k;
            end
        end
        chk("t1_pulses", npulse, 10);
        chk("t1_spacing", errs, 0);

        // 2: row 2 / col 1; detect 4 edges after alignment, pulse 8 later
        align_col(2'd1);
        pressed[2][1] = 1'b1;
        exp_q.push_back(4'b1001);
        wait_valid(30, n);
        chk("t2_valid_latency", n, 12);
        chk("t2_held_at_pulse", bus.key_held, 1);
        errs = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.scan_counter_en || !bus.key_held || bus.key_valid) errs++;
        end
        chk("t2_hold_quiet", errs, 0);
        // release: 2 sync + 1 detect + 8 debounce
        pressed[2][1] = 1'b0;
        wait_held_low(30, n, e);
        chk("t2_release_latency", n, 11);
        chk("t2_release_no_en", e, 0);
        wait_en(10, m);
        chk("t2_scan_resume", m, 4);

        // 3: press bounce, only 3 low cycles seen in debounce
        align_col(2'd2);
        pressed[1][2] = 1'b1;
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.scan_counter_en) errs++;
        end
        chk("t3_frozen", errs, 0);
        pressed[1][2] = 1'b0;
        wait_en(20, n);
        chk("t3_resume", n, 7);
        chk("t3_held", bus.key_held, 0);

        // 4: release bounce on row 0 / col 3
        align_col(2'd3);
        pressed[0][3] = 1'b1;
        exp_q.push_back(4'b0011);
        wait_valid(30, n);
        chk("t4_valid_latency", n, 12);
        repeat (5) @(negedge clk);
        errs = 0;
        pressed[0][3] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!bus.key_held || bus.scan_counter_en) errs++;
        end
        pressed[0][3] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (!bus.key_held || bus.scan_counter_en) errs++;
        end
        pressed[0][3] = 1'b0;
        chk("t4_held_bounce", errs, 0);
        wait_held_low(40, n, e);
        chk("t4_release_latency", n, 11);
        chk("t4_release_no_en", e, 0);

        // 5: rows 1 and 3 on column 2, lowest row wins
        align_col(2'd2);
        pressed[1][2] = 1'b1;
        pressed[3][2] = 1'b1;
        exp_q.push_back(4'b0110);
        wait_valid(30, n);
        chk("t5_valid_latency", n, 12);
        repeat (4) @(negedge clk);
        pressed[1][2] = 1'b0;
        pressed[3][2] = 1'b0;
        wait_held_low(30, n, e);
        chk("t5_release_latency", n, 11);

        // 6: reset in HELD with key down, then re-detection
        align_col(2'd0);
        pressed[3][0] = 1'b1;
        exp_q.push_back(4'b1100);
        wait_valid(30, n);
        chk("t6_valid_latency", n, 12);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        cexp = ~(4'b0001 << cnt);
        chk("t6_cols_in_reset", bus.cols_n, cexp);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_rst_held", bus.key_held, 0);
        chk("t6_rst_valid", bus.key_valid, 0);
        chk("t6_rst_en", bus.scan_counter_en, 0);
        chk("t6_rst_code", bus.key_code, 0);
        // dwell restarts at 0: detect on 4th edge, pulse 8 edges later
        exp_q.push_back(4'b1100);
        wait_valid(30, n);
        chk("t6_redetect_latency", n, 12);
        repeat (3) @(negedge clk);
        pressed[3][0] = 1'b0;
        wait_held_low(30, n, e);
        chk("t6_release_latency", n, 11);

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
